// File: rtl/gshare_branch_predictor_if.sv
// Fetch/EX side bundle for the gshare branch predictor: prediction outputs,
// EX resolution inputs and optional statistics counters.
interface gshare_bp_if #(
    parameter int unsigned HIST_BITS = 5
);
    logic [31:0]          current_pc;
    logic                 fetch_advance;
    logic [31:0]          predicted_pc;
    logic                 predict_taken;
    logic [HIST_BITS-1:0] fetch_history;
    logic                 update_valid;
    logic [31:0]          update_pc;
    logic [HIST_BITS-1:0] update_history;
    logic                 update_is_cond;
    logic                 update_taken;
    logic [31:0]          update_target;
    logic                 mispredict;
    logic [31:0]          stat_updates;
    logic [31:0]          stat_mispredicts;

    modport master (
        output current_pc, fetch_advance,
        output update_valid, update_pc, update_history, update_is_cond,
        output update_taken, update_target, mispredict,
        input  predicted_pc, predict_taken, fetch_history,
        input  stat_updates, stat_mispredicts
    );

    modport slave (
        input  current_pc, fetch_advance,
        input  update_valid, update_pc, update_history, update_is_cond,
        input  update_taken, update_target, mispredict,
        output predicted_pc, predict_taken, fetch_history,
        output stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Fetch-stage next-PC generator: direct-mapped BTB plus gshare PHT with
// speculative global history. Optional counters enabled by PREDICTOR_STATS_EN.
module gshare_branch_predictor #(
    parameter int unsigned HIST_BITS      = 5,
    parameter int unsigned BTB_INDEX_BITS = 5
) (
    input logic       clk,
    input logic       reset,
    gshare_bp_if.slave bp
);
    localparam int unsigned PHT_DEPTH = 1 << HIST_BITS;
    localparam int unsigned BTB_DEPTH = 1 << BTB_INDEX_BITS;
    localparam int unsigned TAG_BITS  = 30 - BTB_INDEX_BITS;

    logic [HIST_BITS-1:0] bhr;
    logic [1:0]           pht [PHT_DEPTH];
    logic [BTB_DEPTH-1:0] btb_valid;
    logic [BTB_DEPTH-1:0] btb_is_cond;
    logic [TAG_BITS-1:0]  btb_tag [BTB_DEPTH];
    logic [31:0]          btb_target [BTB_DEPTH];

    logic [BTB_INDEX_BITS-1:0] fetch_idx;
    logic [HIST_BITS-1:0]      fetch_pht_idx;
    logic                      btb_hit;
    logic                      fetch_is_cond;

    logic [BTB_INDEX_BITS-1:0] upd_idx;
    logic [HIST_BITS-1:0]      upd_pht_idx;
    logic [1:0]                upd_ctr;
    logic [1:0]                upd_ctr_next;
    logic                      btb_write;
    logic                      unused_pc_bits;

    assign unused_pc_bits = ^{bp.current_pc[1:0], bp.update_pc[1:0]};

    // Zero-latency prediction from the current fetch PC
    assign fetch_idx     = bp.current_pc[BTB_INDEX_BITS+1:2];
    assign fetch_is_cond = btb_is_cond[fetch_idx];
    assign btb_hit       = btb_valid[fetch_idx]
                        && (btb_tag[fetch_idx] == bp.current_pc[31:BTB_INDEX_BITS+2]);
    assign fetch_pht_idx = bp.current_pc[HIST_BITS+1:2] ^ bhr;

    assign bp.predict_taken = btb_hit && (!fetch_is_cond || pht[fetch_pht_idx][1]);
    assign bp.predicted_pc  = bp.predict_taken ? btb_target[fetch_idx]
                                               : bp.current_pc + 32'd4;
    assign bp.fetch_history = bhr;

    // Global history: EX repair wins over a same-cycle speculative shift
    always_ff @(posedge clk) begin
        if (reset) begin
            bhr <= '0;
        end else if (bp.update_valid && bp.mispredict) begin
            bhr <= bp.update_is_cond ? {bp.update_history[HIST_BITS-2:0], bp.update_taken}
                                     : bp.update_history;
        end else if (bp.fetch_advance && btb_hit && fetch_is_cond) begin
            bhr <= {bhr[HIST_BITS-2:0], bp.predict_taken};
        end
    end

    assign upd_pht_idx = bp.update_pc[HIST_BITS+1:2] ^ bp.update_history;
    assign upd_ctr     = pht[upd_pht_idx];

    // 2-bit saturating counter step
    always_comb begin
        upd_ctr_next = upd_ctr;
        if (bp.update_taken) begin
            if (upd_ctr != 2'd3) upd_ctr_next = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'd0) upd_ctr_next = upd_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pht <= '{default: 2'b01};
        end else if (bp.update_valid && bp.update_is_cond) begin
            pht[upd_pht_idx] <= upd_ctr_next;
        end
    end

    // BTB allocates only on taken resolutions; not-taken never invalidates
    assign upd_idx   = bp.update_pc[BTB_INDEX_BITS+1:2];
    assign btb_write = bp.update_valid && bp.update_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid   <= '0;
            btb_is_cond <= '0;
        end else if (btb_write) begin
            btb_valid[upd_idx]   <= 1'b1;
            btb_is_cond[upd_idx] <= bp.update_is_cond;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && btb_write) begin
            btb_tag[upd_idx]    <= bp.update_pc[31:BTB_INDEX_BITS+2];
            btb_target[upd_idx] <= bp.update_target;
        end
    end

`ifdef PREDICTOR_STATS_EN
    logic [31:0] stat_updates_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (bp.update_valid) stat_updates_q <= stat_updates_q + 32'd1;
            if (bp.update_valid && bp.mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign bp.stat_updates     = stat_updates_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;
`else
    assign bp.stat_updates     = '0;
    assign bp.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench for gshare_branch_predictor: the driver queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_gshare_branch_predictor;
    localparam int unsigned HB = 5;
`ifdef PREDICTOR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        tk;
        logic [4:0]  h;
        bit          st;
        logic [31:0] su;
        logic [31:0] sm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;
    logic done = 1'b0;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    gshare_bp_if #(.HIST_BITS(HB)) bp ();

    gshare_branch_predictor #(.HIST_BITS(HB), .BTB_INDEX_BITS(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] stv(input int v);
        return STATS_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // One cycle: drive inputs, optionally queue the expected outputs, then step
    task automatic cyc(input int id, input bit rst, input logic [31:0] pc, input bit fa,
                       input bit uv, input logic [31:0] upc, input logic [4:0] uh,
                       input bit uc, input bit ut, input logic [31:0] utgt, input bit mis,
                       input bit chk, input logic [31:0] e_pc, input bit e_tk, input logic [4:0] e_h,
                       input bit st, input logic [31:0] su, input logic [31:0] sm);
        exp_t e;
        reset = rst;
        bp.current_pc = pc; bp.fetch_advance = fa;
        bp.update_valid = uv; bp.update_pc = upc; bp.update_history = uh;
        bp.update_is_cond = uc; bp.update_taken = ut; bp.update_target = utgt;
        bp.mispredict = mis;
        chk_en = chk;
        if (chk) begin
            e.id = id; e.pc = e_pc; e.tk = e_tk; e.h = e_h; e.st = st; e.su = su; e.sm = sm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic look(input int id, input logic [31:0] pc, input bit fa,
                        input logic [31:0] e_pc, input bit e_tk, input logic [4:0] e_h);
        cyc(id, 0, pc, fa, 0, 0, 0, 0, 0, 0, 0, 1, e_pc, e_tk, e_h, 0, 0, 0);
    endtask

    task automatic upd(input int id, input logic [31:0] pc, input bit fa,
                       input logic [31:0] upc, input logic [4:0] uh, input bit uc, input bit ut,
                       input logic [31:0] utgt, input bit mis,
                       input logic [31:0] e_pc, input bit e_tk, input logic [4:0] e_h);
        cyc(id, 0, pc, fa, 1, upc, uh, uc, ut, utgt, mis, 1, e_pc, e_tk, e_h, 0, 0, 0);
    endtask

    // Monitor: compares whenever the driver flags a sampled cycle
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard: sample with no queued expectation");
            end else begin
                e = sb.pop_front();
                check(e.id, "predicted_pc", bp.predicted_pc, e.pc);
                check(e.id, "predict_taken", 32'(bp.predict_taken), 32'(e.tk));
                check(e.id, "fetch_history", 32'(bp.fetch_history), 32'(e.h));
                if (e.st) begin
                    check(e.id, "stat_updates", bp.stat_updates, e.su);
                    check(e.id, "stat_mispredicts", bp.stat_mispredicts, e.sm);
                end
            end
        end
        if (done) begin
            check(-1, "leftover_expectations", 32'(sb.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        // Reset, then idle state at 0x100
        cyc(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 5'd0, 1, 0, 0);
        // Learn taken conditional: same-cycle read sees old state
        upd(2, 32'h100, 0, 32'h100, 5'd0, 1, 1, 32'h80, 0, 32'h104, 0, 5'd0);
        look(3, 32'h100, 0, 32'h80, 1, 5'd0);
        // Saturate up to 3, then walk down to 0
        for (int i = 0; i < 4; i++)
            upd(4 + i, 32'h100, 0, 32'h100, 5'd0, 1, 1, 32'h80, 0, 32'h80, 1, 5'd0);
        upd(8, 32'h100, 0, 32'h100, 5'd0, 1, 0, 32'h0, 0, 32'h80, 1, 5'd0);
        upd(9, 32'h100, 0, 32'h100, 5'd0, 1, 0, 32'h0, 0, 32'h80, 1, 5'd0);
        upd(10, 32'h100, 0, 32'h100, 5'd0, 1, 0, 32'h0, 0, 32'h104, 0, 5'd0);
        look(11, 32'h100, 0, 32'h104, 0, 5'd0);
        // Retrain PHT[0] and PHT[1] so two speculative fetches predict taken
        upd(12, 32'h100, 0, 32'h100, 5'd0, 1, 1, 32'h80, 0, 32'h104, 0, 5'd0);
        upd(13, 32'h100, 0, 32'h100, 5'd0, 1, 1, 32'h80, 0, 32'h104, 0, 5'd0);
        upd(14, 32'h100, 0, 32'h100, 5'd1, 1, 1, 32'h80, 0, 32'h80, 1, 5'd0);
        look(15, 32'h100, 1, 32'h80, 1, 5'd0);
        look(16, 32'h100, 1, 32'h80, 1, 5'd1);
        // Mispredict repair overrides the same-cycle shift
        upd(17, 32'h100, 1, 32'h100, 5'b00110, 1, 1, 32'h80, 1, 32'h104, 0, 5'b00011);
        look(18, 32'h100, 0, 32'h104, 0, 5'b01101);
        // Unconditional jump at 0x40: taken without PHT, history untouched
        upd(19, 32'h40, 0, 32'h40, 5'd0, 0, 1, 32'h200, 0, 32'h44, 0, 5'b01101);
        look(20, 32'h40, 1, 32'h200, 1, 5'b01101);
        look(21, 32'h40, 1, 32'h200, 1, 5'b01101);
        // Tag mismatch on the same index, and PC wraparound
        look(22, 32'h1040, 0, 32'h1044, 0, 5'b01101);
        cyc(23, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 5'b01101, 1, stv(13), stv(1));
        // Reset with a same-cycle taken update: update discarded
        cyc(24, 1, 32'h300, 1, 1, 32'h300, 5'd0, 0, 1, 32'h500, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(25, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 5'd0, 1, 0, 0);
        look(26, 32'h300, 0, 32'h304, 0, 5'd0);
        look(27, 32'h40, 0, 32'h44, 0, 5'd0);
        // Three updates, one mispredict
        upd(28, 32'h100, 0, 32'h200, 5'd0, 1, 0, 32'h0, 0, 32'h104, 0, 5'd0);
        upd(29, 32'h100, 0, 32'h200, 5'd0, 1, 0, 32'h0, 1, 32'h104, 0, 5'd0);
        upd(30, 32'h100, 0, 32'h600, 5'd0, 0, 1, 32'h700, 0, 32'h104, 0, 5'd0);
        cyc(31, 0, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h700, 1, 5'd0, 1, stv(3), stv(1));
        chk_en = 1'b0;
        done = 1'b1;
    end
endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Fetch-stage next-PC generator; sits directly upstream of the PC register and supplies its next_pc input.
- Combines a direct-mapped BTB with a gshare pattern history table (2-bit saturating counters indexed by PC XOR global history).
- Global history is updated speculatively at fetch and repaired by the EX stage on mispredict.

Parameters:
- HIST_BITS, 5: global history length; PHT depth = 2^HIST_BITS.
- BTB_INDEX_BITS, 5: BTB depth = 2^BTB_INDEX_BITS; tag = current_pc[31:BTB_INDEX_BITS+2].

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- current_pc  input  32  PC being fetched (PC register output).
- fetch_advance  input  1  fetch proceeds this cycle (same signal as PC pc_write).
- predicted_pc  output  32  next_pc for the PC register.
- predict_taken  output  1  prediction for current_pc.
- fetch_history  output  HIST_BITS  BHR value used for this prediction; piped to EX.
- update_valid  input  1  EX resolved a control instruction.
- update_pc  input  32  PC of the resolved instruction.
- update_history  input  HIST_BITS  fetch_history captured with that instruction.
- update_is_cond  input  1  1 = conditional branch, 0 = jal/jalr.
- update_taken  input  1  actual direction.
- update_target  input  32  actual target.
- mispredict  input  1  EX flush; qualified by update_valid.
- stat_updates  output  32  see Optional Feature.
- stat_mispredicts  output  32  see Optional Feature.

Behaviour:
- Prediction path is combinational, zero latency from current_pc.
  - btb_hit = valid[idx] && tag[idx] == current_pc tag, where idx = current_pc[BTB_INDEX_BITS+1:2].
  - pht_idx = current_pc[HIST_BITS+1:2] XOR bhr.
  - predict_taken = btb_hit && (!is_cond[idx] || pht[pht_idx][1]).
  - predicted_pc = predict_taken ? btb_target[idx] : current_pc + 4 (modulo 2^32).
  - fetch_history = bhr.
- Reset state: bhr = 0; all PHT entries = 2'b01 (weakly not-taken); all BTB valid = 0.
  - After reset, predict_taken = 0 and predicted_pc = current_pc + 4.
- BHR update priority, evaluated per cycle:
  - 1. reset.
  - 2. update_valid && mispredict: bhr <= update_is_cond ? {update_history[HIST_BITS-2:0], update_taken} : update_history.
  - 3. fetch_advance && btb_hit && is_cond[idx]: bhr <= {bhr[HIST_BITS-2:0], predict_taken}.
  - 4. Otherwise hold.
  - Mispredict repair overrides a same-cycle speculative shift.
- PHT update on update_valid && update_is_cond:
  - Index = update_pc[HIST_BITS+1:2] XOR update_history.
  - Taken: increment, saturating at 3. Not-taken: decrement, saturating at 0.
- BTB update on update_valid && update_taken:
  - Write valid=1, tag, target=update_target, is_cond=update_is_cond.
  - A not-taken update never allocates and never invalidates.
- Read/write to the same PHT or BTB entry in one cycle: the prediction uses the pre-update value; the new value is visible the next cycle.
- fetch_advance=0 freezes speculative history only; EX updates still apply.
- Reset asserted mid-operation discards any same-cycle update.

Optional Feature:
- Macro: PREDICTOR_STATS_EN.
- Defined:
  - stat_updates increments on each update_valid.
  - stat_mispredicts increments on each update_valid && mispredict.
  - Both counters are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Post-reset: reset 1 cycle, current_pc=0x100 -> predict_taken=0, predicted_pc=0x104, fetch_history=0.
- Learn conditional branch: update_valid=1, update_pc=0x100, update_history=0, update_is_cond=1, update_taken=1, update_target=0x80, mispredict=0. Next cycle current_pc=0x100, bhr=0 -> PHT[0]=2, predict_taken=1, predicted_pc=0x80.
- Saturation: 4 taken updates at pc 0x100, history 0 -> PHT[0]=3. Then 1 not-taken update -> PHT[0]=2, still predicts 0x80. Then 2 more not-taken -> PHT[0]=0, predicted_pc=0x104.
- Speculation and repair:
  - With the 0x100 entry predicting taken and fetch_advance=1 for 2 cycles -> bhr=5'b00011.
  - Then mispredict: update_history=5'b00110, update_is_cond=1, update_taken=1, fetch_advance=1 same cycle -> bhr=5'b01101 next cycle.
- Unconditional jump: update at pc 0x40, update_is_cond=0, update_taken=1, target 0x200. Next cycle current_pc=0x40, fetch_advance=1 -> predicted_pc=0x200 regardless of PHT, bhr unchanged.
- Reset mid-update plus stats:
  - Assert reset together with a taken update -> BTB empty and counters 0 after.
  - With PREDICTOR_STATS_EN, 3 updates (1 mispredict) -> stat_updates=3, stat_mispredicts=1.
